// File: rtl/display_sequencer.sv
// Display path controller for the clock: generates the counter tick,
// walks the digit mux, feeds each digit to the serial shift register over
// a load/busy handshake and finally pulses the display latch.
module display_sequencer #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_srbusy,
  input  logic             i_force_refresh,
  output logic             o_srload,
  output logic [SEL_W-1:0] o_muxsel,
  output logic             o_latch,
  output logic             o_cnt_en,
  output logic             o_frame_busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(NUM_DIGITS - 1);
  localparam logic [LW-1:0]    LAT_LAST  = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_LATCH
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             cnt_en_q;
  logic             pend_q, pend_d;
  logic             srload_q;
  logic             latch_q;
  logic             fbusy_q;
  logic [SEL_W-1:0] muxsel_q;
  logic [LW-1:0]    lcnt_q;

  // Prescaler next value: free-running wrap at TICK_DIV-1.
  always_comb begin
    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
  end

  // Prescaler and count-enable; the tick is registered from the next
  // count so it is high exactly while the count sits at TICK_DIV-1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      presc_q  <= '0;
      cnt_en_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_en_q <= (presc_d == PRE_LAST);
    end
  end

  // Pending refresh: new requests win over the IDLE consumption so a
  // request arriving on the frame-start cycle still gets its own frame.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_IDLE) begin
      pend_d = 1'b0;
    end
    if (cnt_en_q || i_force_refresh) begin
      pend_d = 1'b1;
    end
  end

  // Pending flag register; set out of reset so the display gets painted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend_q <= 1'b1;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Frame sequencer with registered strobes and mux select.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      srload_q <= 1'b0;
      latch_q  <= 1'b0;
      fbusy_q  <= 1'b0;
      muxsel_q <= SEL_FIRST;
      lcnt_q   <= '0;
    end else begin
      srload_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            muxsel_q <= SEL_FIRST;
            fbusy_q  <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!i_srbusy) begin
            srload_q <= 1'b1;
            state_q  <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (i_srbusy) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!i_srbusy) begin
            if (muxsel_q == '0) begin
              latch_q <= 1'b1;
              lcnt_q  <= '0;
              state_q <= S_LATCH;
            end else begin
              muxsel_q <= muxsel_q - 1'b1;
              state_q  <= S_LOAD;
            end
          end
        end
        S_LATCH: begin
          if (lcnt_q == LAT_LAST) begin
            latch_q <= 1'b0;
            fbusy_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_srload     = srload_q;
  assign o_muxsel     = muxsel_q;
  assign o_latch      = latch_q;
  assign o_cnt_en     = cnt_en_q;
  assign o_frame_busy = fbusy_q;

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
Controller for the clock's display path: the time-base, the 6:1 digit mux, the serial output shift register and the display latch. It generates the one-cycle count-enable tick for the BCD counters. On each tick or forced refresh it walks the mux across all digits, hands each decoded digit to the shift register over a load/busy handshake, then pulses the latch. Sits beside the counters and the shift register at the top of the clock design.

Parameters:
TICK_DIV, 1000, clock cycles per o_cnt_en pulse (>= 2)
NUM_DIGITS, 6, digits shifted per frame (2..8)
SEL_W, 3, width of o_muxsel (2^SEL_W >= NUM_DIGITS)
LATCH_CYCLES, 2, width of o_latch pulse in cycles (>= 1)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  synchronous active-low reset
i_srbusy  input  1  shift register busy; high while shifting a byte
i_force_refresh  input  1  request an immediate frame, e.g. from the set-button edges; any width pulse
o_srload  output  1  one-cycle load strobe to the shift register
o_muxsel  output  SEL_W  digit select to the mux (0 = seconds units)
o_latch  output  1  display latch pulse, high for LATCH_CYCLES cycles
o_cnt_en  output  1  one-cycle count-enable tick to the seconds counter
o_frame_busy  output  1  high from frame start until the latch pulse ends

Behaviour:
- Reset (i_rst_n low at clock edge): prescaler=0, state=IDLE, o_srload=0, o_latch=0, o_cnt_en=0, o_frame_busy=0, o_muxsel=NUM_DIGITS-1, refresh_pending=1 (the display is painted right after reset). Reset overrides any in-flight frame; nothing is latched.
- Prescaler: counts 0..TICK_DIV-1 and wraps. o_cnt_en=1 for exactly the cycle in which the count equals TICK_DIV-1. The prescaler runs freely and is never stalled by frames.
- Refresh request: refresh_pending is set the cycle after o_cnt_en=1, so the frame sees the updated counters. It is also set on any cycle with i_force_refresh=1. Requests arriving during a frame are coalesced into one pending flag and serviced by exactly one further frame.
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE, LATCH.
- IDLE: if refresh_pending: clear it, set o_muxsel=NUM_DIGITS-1, o_frame_busy=1, go to LOAD.
- LOAD: if i_srbusy=0, drive o_srload=1 for this cycle only and go to WAIT_START. Otherwise hold in LOAD.
- WAIT_START: wait for i_srbusy=1, then go to WAIT_DONE. No timeout.
- WAIT_DONE: wait for i_srbusy=0. Then, if o_muxsel==0, go to LATCH with the counter at 0. Otherwise decrement o_muxsel and go to LOAD.
- LATCH: o_latch=1 for LATCH_CYCLES cycles, then go to IDLE with o_frame_busy=0. A pending request starts the next frame from IDLE on the following cycle.
- o_muxsel is stable from entry to LOAD until exit from WAIT_DONE. It changes only on the WAIT_DONE->LOAD transition and on frame start.
- Digit order is most-significant first (NUM_DIGITS-1 down to 0). The hours-tens digit therefore ends farthest down the chain.
- o_srload is never asserted while i_srbusy=1, and is never asserted twice without an intervening busy high->low.
- Minimum frame length, for a shift register with 1-cycle busy response and B busy cycles: NUM_DIGITS*(B+3)+LATCH_CYCLES+1 cycles.
- Simultaneous o_cnt_en and frame end: the pending flag is set and the next frame follows without loss.

Test Plan:
- Reset release, TICK_DIV=8, SR model with busy 1 cycle after load lasting 8 cycles -> first frame starts within 1 cycle. o_srload pulses 6 times with o_muxsel 5,4,3,2,1,0. One o_latch pulse of 2 cycles, then o_frame_busy=0.
- Free run 100 cycles, TICK_DIV=8 -> o_cnt_en pulses every 8th cycle, each 1 cycle wide. The first pulse falls on cycle 7 after reset release.
- Three i_force_refresh pulses during one frame -> exactly one additional frame follows, and o_frame_busy drops only after its latch.
- Hold i_srbusy=1 for 20 cycles at LOAD entry -> o_srload stays 0 until busy falls, and o_muxsel is unchanged throughout.
- Assert i_rst_n=0 mid-frame at o_muxsel=3 -> next cycle o_srload=0, o_latch=0, o_muxsel=5. No latch occurs for the aborted frame, and a fresh full frame follows reset release.
- TICK_DIV=2 with a frame longer than the tick period -> the prescaler never stalls and frames run back-to-back, each complete (6 loads + latch).
